// File: rtl/strobe_decimator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : strobe_decimator                                              |
// | Purpose  : Accumulates valid input samples between window-end strobes,   |
// |            scales the window sum by an arithmetic right shift, saturates |
// |            it to the output width and queues it in a first-word-fall-    |
// |            through FIFO drained through a valid/ready handshake.         |
// | Ports    : in_clk   - clock, rising edge                                 |
// |            rst      - asynchronous active-low reset                      |
// |            smp_stb  - one-cycle window-end strobe                        |
// |            din      - signed input sample, qualified by din_vld          |
// |            dout     - head-of-FIFO sample (0 when dout_vld = 0)          |
// |            dout_vld - FIFO not empty                                     |
// |            dout_rdy - consumer accepts dout this cycle                   |
// |            level    - registered FIFO occupancy                          |
// |            ovf      - sticky flag, a result was dropped                  |
// |            clr_ovf  - synchronous clear of ovf                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module strobe_decimator #(
  parameter int DW    = 16,
  parameter int ACCW  = 24,
  parameter int SHIFT = 5,
  parameter int DEPTH = 4
) (
  input  logic                       in_clk,
  input  logic                       rst,
  input  logic                       smp_stb,
  input  logic signed [DW-1:0]       din,
  input  logic                       din_vld,
  output logic signed [DW-1:0]       dout,
  output logic                       dout_vld,
  input  logic                       dout_rdy,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);

  localparam logic signed [ACCW-1:0] c_sat_max = ACCW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  // -2^(DW-1) is the bitwise complement of 2^(DW-1)-1
  localparam logic signed [ACCW-1:0] c_sat_min = ~c_sat_max;
  localparam logic [AW:0]            c_depth   = (AW + 1)'(DEPTH);

  logic signed [ACCW-1:0] r_acc;
  logic signed [ACCW-1:0] w_din_ext;
  logic signed [ACCW-1:0] w_sum;
  logic signed [ACCW-1:0] w_shifted;
  logic signed [ACCW-1:0] w_sat;
  logic signed [DW-1:0]   w_res;

  logic signed [DW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_level;
  logic                   r_ovf;

  logic                   w_vld;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push_ok;
  logic                   w_drop;

  // ---------------------------------------------------------------- datapath
  assign w_din_ext = din_vld ? ACCW'(din) : '0;

  // A sample on the strobe cycle closes the current window.
  assign w_sum     = r_acc + w_din_ext;
  assign w_shifted = w_sum >>> SHIFT;

  always_comb begin
    w_sat = w_shifted;
    if (w_shifted > c_sat_max) begin
      w_sat = c_sat_max;
    end else if (w_shifted < c_sat_min) begin
      w_sat = c_sat_min;
    end
  end

  assign w_res = DW'(w_sat);

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (smp_stb) begin
      r_acc <= '0;
    end else if (din_vld) begin
      r_acc <= w_sum;
    end
  end

  // -------------------------------------------------------------------- FIFO
  // Full/empty come from the occupancy counter, never from pointer equality.
  assign w_vld     = (r_level != '0);
  assign w_full    = (r_level == c_depth);
  assign w_pop     = w_vld && dout_rdy;
  // When full, a same-cycle pop frees the slot the write pointer points at.
  assign w_push_ok = smp_stb && (!w_full || w_pop);
  assign w_drop    = smp_stb && !w_push_ok;

  always_ff @(posedge in_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= w_res;
    end
  end

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Set has priority over clear.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  // ----------------------------------------------------------------- outputs
  // Driven only from registers, so no path from dout_rdy, din or smp_stb.
  assign dout_vld = w_vld;
  assign dout     = w_vld ? r_mem[r_rd_ptr] : '0;
  assign level    = r_level;
  assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_strobe_decimator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_strobe_decimator                                           |
// | Purpose  : Directed bench for strobe_decimator (SHIFT = 2). Expected     |
// |            results are queued when a strobe is issued; a monitor pops    |
// |            and compares whenever the DUT hands over a word.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_strobe_decimator;

  localparam int DW    = 16;
  localparam int ACCW  = 24;
  localparam int SHIFT = 2;
  localparam int DEPTH = 4;

  logic                   in_clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   smp_stb = 1'b0;
  logic signed [DW-1:0]   din = '0;
  logic                   din_vld = 1'b0;
  logic signed [DW-1:0]   dout;
  logic                   dout_vld;
  logic                   dout_rdy = 1'b0;
  logic [$clog2(DEPTH):0] level;
  logic                   ovf;
  logic                   clr_ovf = 1'b0;

  int checks = 0;
  int failures = 0;
  int sb[$];

  strobe_decimator #(.DW(DW), .ACCW(ACCW), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .in_clk   (in_clk),
    .rst      (rst),
    .smp_stb  (smp_stb),
    .din      (din),
    .din_vld  (din_vld),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .level    (level),
    .ovf      (ovf),
    .clr_ovf  (clr_ovf)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock with the given inputs; inputs return to idle just after the edge.
  task automatic step(input logic stb, input int d, input logic v);
    smp_stb = stb;
    din     = DW'(d);
    din_vld = v;
    @(posedge in_clk);
    #1;
    smp_stb = 1'b0;
    din_vld = 1'b0;
    din     = '0;
  endtask

  task automatic strobe_push(input int d, input logic v, input int exp);
    step(1'b1, d, v);
    sb.push_back(exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
  endtask

  // Monitor: a word is consumed at the next edge when dout_vld && dout_rdy.
  always @(negedge in_clk) begin
    if (rst) begin
      if (dout_vld && dout_rdy) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got %0d, expected no word", $signed(dout));
        end else begin
          chk("dout_word", int'($signed(dout)), sb.pop_front());
        end
      end else if (!dout_vld) begin
        chk("dout_zero_when_empty", int'($signed(dout)), 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- reset values
    #12;
    chk("rst_dout", int'($signed(dout)), 0);
    chk("rst_vld", int'(dout_vld), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(negedge in_clk);
    rst = 1'b1;
    @(posedge in_clk);
    #1;

    // ---- basic window: 4 x 8 = 32, >>>2 = 8
    dout_rdy = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 8, 1'b1);
    strobe_push(8, 1'b1, 8);
    chk("basic_vld", int'(dout_vld), 1);
    chk("basic_dout", int'($signed(dout)), 8);
    chk("basic_level", int'(level), 1);
    idle(1);
    chk("basic_vld_drop", int'(dout_vld), 0);
    chk("basic_level_drop", int'(level), 0);

    // ---- negative floor: -9 >>> 2 = -3 ; -1 >>> 2 = -1
    for (int i = 0; i < 3; i++) step(1'b0, -3, 1'b1);
    strobe_push(0, 1'b0, -3);
    chk("neg_dout", int'($signed(dout)), -3);
    idle(1);
    strobe_push(-1, 1'b1, -1);
    chk("neg1_dout", int'($signed(dout)), -1);
    idle(1);

    // ---- saturation: 8*32767 >>> 2 = 65534 -> 32767 ; 8*-32768 >>> 2 -> -32768
    for (int i = 0; i < 7; i++) step(1'b0, 32767, 1'b1);
    strobe_push(32767, 1'b1, 32767);
    chk("sat_pos", int'($signed(dout)), 32767);
    idle(1);
    for (int i = 0; i < 7; i++) step(1'b0, -32768, 1'b1);
    strobe_push(-32768, 1'b1, -32768);
    chk("sat_neg", int'($signed(dout)), -32768);
    idle(1);

    // ---- empty window pushes 0, back-to-back strobes each push
    strobe_push(0, 1'b0, 0);
    strobe_push(12, 1'b1, 3);
    idle(2);
    chk("b2b_level", int'(level), 0);

    // ---- overflow: results 1..5 into a 4-deep FIFO with no consumer
    dout_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) strobe_push(4 * k, 1'b1, k);
    chk("ovf_before", int'(ovf), 0);
    step(1'b1, 20, 1'b1);                 // dropped
    chk("ovf_level", int'(level), 4);
    chk("ovf_set", int'(ovf), 1);
    dout_rdy = 1'b1;
    idle(4);
    chk("ovf_drained", int'(level), 0);
    chk("ovf_sticky", int'(ovf), 1);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    chk("ovf_clear", int'(ovf), 0);

    // ---- full with simultaneous pop and push: drain 2,3,4,9
    dout_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) strobe_push(4 * k, 1'b1, k);
    dout_rdy = 1'b1;
    strobe_push(36, 1'b1, 9);
    chk("fullpp_level", int'(level), 4);
    chk("fullpp_ovf", int'(ovf), 0);
    idle(4);
    chk("fullpp_drained", int'(level), 0);

    // ---- asynchronous reset with three queued words
    dout_rdy = 1'b0;
    for (int k = 1; k <= 3; k++) strobe_push(4 * k, 1'b1, k);
    step(1'b0, 100, 1'b1);                // partial window, lost by reset
    chk("pre_rst_level", int'(level), 3);
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    chk("arst_dout", int'($signed(dout)), 0);
    chk("arst_vld", int'(dout_vld), 0);
    chk("arst_level", int'(level), 0);
    chk("arst_ovf", int'(ovf), 0);
    @(negedge in_clk);
    rst = 1'b1;
    @(posedge in_clk);
    #1;
    strobe_push(0, 1'b0, 0);
    chk("post_rst_vld", int'(dout_vld), 1);
    chk("post_rst_dout", int'($signed(dout)), 0);
    dout_rdy = 1'b1;
    idle(3);

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/strobe_decimator.md
# strobe_decimator

Consumes the one-cycle sample strobe from the RACE filter clock divider and turns a full-rate input sample stream into a decimated stream. It accumulates valid input samples between strobes, scales and saturates the window sum on each strobe, and queues the result in a small FIFO. The FIFO drains through a valid/ready handshake into the adaptive filter core.

## Interface
- DW, 16: input/output sample width, signed two's complement.
- ACCW, 24: accumulator width, signed; must be ≥ DW.
- SHIFT, 5: arithmetic right shift applied to the window sum, 0 ≤ SHIFT < ACCW.
- DEPTH, 4: output FIFO depth; power of two, ≥ 2.

- in_clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- smp_stb  input  1  window-end strobe, one in_clk cycle wide (divider output).
- din  input  DW  input sample, signed.
- din_vld  input  1  din is valid this cycle.
- dout  output  DW  head-of-FIFO decimated sample; 0 when dout_vld = 0.
- dout_vld  output  1  FIFO not empty.
- dout_rdy  input  1  consumer accepts dout this cycle.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- ovf  output  1  sticky overflow flag: a result was dropped.
- clr_ovf  input  1  synchronous clear of ovf.

## Operation
- **Accumulator acc (ACCW, signed).**
  - If smp_stb = 0 and din_vld = 1: acc ← acc + sext(din).
  - If smp_stb = 1: window sum S = acc + (din_vld ? sext(din) : 0). A sample arriving on the strobe cycle belongs to the closing window. Then acc ← 0.
  - Additions wrap modulo 2^ACCW. There is no accumulator saturation; choose ACCW for the worst-case window.
- **Result:** R = S >>> SHIFT (floor, sign-preserving), then saturated to [−2^(DW−1), 2^(DW−1)−1].
- **FIFO:** circular buffer of DEPTH entries, first-word-fall-through.
  - Push on a smp_stb cycle.
  - Pop when dout_vld && dout_rdy.
  - A push is accepted if level < DEPTH, or if a pop occurs in the same cycle.
  - Simultaneous push and pop: level is unchanged, ordering is preserved, and the popped word is the old head.
  - Push while full with no pop: R is discarded, FIFO contents and pointers are unchanged, and ovf ← 1.
- **ovf:** set by a dropped push, cleared by clr_ovf. If set and clear occur in the same cycle, set wins.
- **Strobe with no valid samples in the window:** pushes R = 0 (still a push, still subject to overflow).
- **Pointer wrap:** pointers wrap modulo DEPTH. full/empty are derived from an extra MSB or from level, never from pointer equality alone.

## Timing
- **Reset values:** acc = 0, FIFO empty, pointers 0, dout = 0, dout_vld = 0, level = 0, ovf = 0.
- **Reset mid-operation:** queued and accumulating data are lost immediately (asynchronous). The first window after reset release starts at the first in_clk edge.
- **Latency:** smp_stb at edge t puts R in the FIFO at t. If the FIFO was empty, dout_vld = 1 and dout = R after t, i.e. one cycle after the strobe cycle.
- **Pop:** a pop at edge t makes the next head (or dout_vld = 0 / dout = 0) visible after t.
- **Combinational paths:** dout and dout_vld have no combinational path from dout_rdy, din, or smp_stb. level is registered.
- **Back-to-back strobes:** on consecutive cycles, each strobe produces one push; S for the second covers at most one sample.
- **ovf timing:** ovf rises the cycle after the dropped strobe.

## Test plan
- **Reset:** assert rst = 0 mid-stream with FIFO at level 3 → dout = 0, dout_vld = 0, level = 0, ovf = 0 immediately. The first strobe after release with no valid input gives dout = 0, dout_vld = 1.
- **Basic window (SHIFT = 2):** din = 8 valid for 4 cycles, smp_stb on the 4th → next cycle dout_vld = 1, dout = 8 (32 >>> 2), level = 1. With dout_rdy = 1, dout_vld drops one cycle later.
- **Negative floor (SHIFT = 2):** din = −3 valid for 3 cycles, then smp_stb with din_vld = 0 → dout = −3 (−9 >>> 2 floors to −3). With din = −1 once → dout = −1.
- **Saturation (SHIFT = 2, DW = 16):** din = 32767 for 8 cycles, strobe on the 8th → dout = 32767. din = −32768 for 8 cycles → dout = −32768.
- **Overflow (DEPTH = 4, dout_rdy = 0):** 5 strobes with results 1..5 → level = 4 and ovf = 1 after the 5th. Draining yields 1, 2, 3, 4 in order. clr_ovf for one cycle → ovf = 0.
- **Full with simultaneous pop and push:** FIFO holds 1..4, dout_rdy = 1 and strobe with R = 9 in the same cycle → level stays 4, ovf stays 0. The drain sequence is 2, 3, 4, 9.
